// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for an RV32I subset (R-type, lw, sw, beq).
// Moore FSM driving a shared datapath and a single shared memory port.
module multicycle_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [6:0]  opcode_i,
  input  logic        zero_i,
  input  logic        mem_ready_i,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        ir_write_o,
  output logic        iord_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        alu_src_a_o,
  output logic [1:0]  alu_src_b_o,
  output logic [1:0]  alu_op_o,
  output logic        reg_write_o,
  output logic        mem_to_reg_o,
  output logic [3:0]  state_o,
  output logic [1:0]  fault_o,
  output logic [31:0] instret_o
);

  typedef enum logic [3:0] {
    S_START    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_WB_MEM   = 4'd6,
    S_EXEC_R   = 4'd7,
    S_WB_R     = 4'd8,
    S_BRANCH   = 4'd9,
    S_TRAP     = 4'd10
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t          state_q, state_d;
  logic [1:0]      fault_q, fault_d;
  logic [31:0]     instret_q, instret_d;
  logic [CW-1:0]   tcnt_q, tcnt_d;

  logic wait_st;
  logic timeout_hit;
  logic retire;

  // Counter only runs while stalled in a memory wait state; any other cycle
  // (including the completing one) leaves it at zero for the next wait state.
  always_comb begin
    wait_st     = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                  (state_q == S_MEM_WR);
    timeout_hit = (TIMEOUT != 0) && !mem_ready_i &&
                  (tcnt_q == CW'(TIMEOUT - 1));
    tcnt_d      = '0;
    if (wait_st && !mem_ready_i) begin
      tcnt_d = tcnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    fault_d   = fault_q;
    retire    = 1'b0;
    case (state_q)
      S_START:  state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready_i) begin
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          fault_d = FAULT_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (opcode_i)
          OP_R:              state_d = S_EXEC_R;
          OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
          OP_BEQ:            state_d = S_BRANCH;
          default: begin
            state_d = S_TRAP;
            fault_d = FAULT_ILLEGAL;
          end
        endcase
      end
      S_MEM_ADDR: state_d = (opcode_i == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready_i) begin
          state_d = S_WB_MEM;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          fault_d = FAULT_TIMEOUT;
        end
      end
      S_MEM_WR: begin
        if (mem_ready_i) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          fault_d = FAULT_TIMEOUT;
        end
      end
      S_WB_MEM: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_EXEC_R: state_d = S_WB_R;
      S_WB_R: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_START;
    endcase
    instret_d = retire ? (instret_q + 32'd1) : instret_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_START;
      fault_q   <= FAULT_NONE;
      instret_q <= '0;
      tcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      fault_q   <= fault_d;
      instret_q <= instret_d;
      tcnt_q    <= tcnt_d;
    end
  end

  // Moore decode; only the FETCH strobes and the branch PC write look at inputs.
  always_comb begin
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    ir_write_o   = 1'b0;
    iord_o       = 1'b0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE:   alu_src_b_o = 2'b10;
      S_MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      S_MEM_RD: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEM_WR: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_WB_MEM: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
      end
      S_WB_R:     reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b01;
        pc_src_o    = 1'b1;
        pc_write_o  = zero_i;
      end
      default: ;
    endcase
  end

  assign state_o   = state_q;
  assign fault_o   = fault_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle expected control vectors are
// queued as inputs are driven and compared against the DUT outputs.
module tb_multicycle_ctrl;

  localparam int W = 19;

  logic        clk_i;
  logic        rst_i;
  logic [6:0]  opcode_i;
  logic        zero_i;
  logic        mem_ready_i;
  logic        pc_write_o;
  logic        pc_src_o;
  logic        ir_write_o;
  logic        iord_o;
  logic        mem_read_o;
  logic        mem_write_o;
  logic        alu_src_a_o;
  logic [1:0]  alu_src_b_o;
  logic [1:0]  alu_op_o;
  logic        reg_write_o;
  logic        mem_to_reg_o;
  logic [3:0]  state_o;
  logic [1:0]  fault_o;
  logic [31:0] instret_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs;
  logic [31:0]  exp_instret;
  logic [1:0]   exp_fault;
  int           total;
  int           bad;

  multicycle_ctrl #(.TIMEOUT(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .opcode_i     (opcode_i),
    .zero_i       (zero_i),
    .mem_ready_i  (mem_ready_i),
    .pc_write_o   (pc_write_o),
    .pc_src_o     (pc_src_o),
    .ir_write_o   (ir_write_o),
    .iord_o       (iord_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .alu_src_a_o  (alu_src_a_o),
    .alu_src_b_o  (alu_src_b_o),
    .alu_op_o     (alu_op_o),
    .reg_write_o  (reg_write_o),
    .mem_to_reg_o (mem_to_reg_o),
    .state_o      (state_o),
    .fault_o      (fault_o),
    .instret_o    (instret_o)
  );

  assign obs = {state_o, pc_write_o, pc_src_o, ir_write_o, iord_o, mem_read_o,
                mem_write_o, alu_src_a_o, alu_src_b_o, alu_op_o, reg_write_o,
                mem_to_reg_o, fault_o};

  // Clock/reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // Expected control vector for a state, straight from the control table.
  function automatic logic [W-1:0] ctl(input logic [3:0] st, input logic rdy,
                                       input logic zr, input logic [1:0] flt);
    logic pcw, pcs, irw, iord, mr, mw, sa, rw, m2r;
    logic [1:0] sb, op;
    pcw = 0; pcs = 0; irw = 0; iord = 0; mr = 0; mw = 0; sa = 0;
    rw = 0; m2r = 0; sb = 2'b00; op = 2'b00;
    case (st)
      4'd1: begin mr = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
      4'd2: sb = 2'b10;
      4'd3: begin sa = 1; sb = 2'b10; end
      4'd4: begin mr = 1; iord = 1; end
      4'd5: begin mw = 1; iord = 1; end
      4'd6: begin rw = 1; m2r = 1; end
      4'd7: begin sa = 1; op = 2'b10; end
      4'd8: rw = 1;
      4'd9: begin sa = 1; op = 2'b01; pcs = 1; pcw = zr; end
      default: ;
    endcase
    return {st, pcw, pcs, irw, iord, mr, mw, sa, sb, op, rw, m2r, flt};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // Scoreboard
  task automatic check(input string tag);
    logic [W-1:0] e;
    e = exp_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
    total++;
    assert (instret_o === exp_instret) else begin
      bad++;
      $error("FAIL %s_instret observed=%h expected=%h", tag, instret_o, exp_instret);
    end
  endtask

  // Driver: one clock cycle, inputs applied on the falling edge.
  task automatic cyc(input logic [3:0] st, input logic rdy, input logic zr,
                     input logic ret, input string tag);
    @(negedge clk_i);
    mem_ready_i = rdy;
    zero_i      = zr;
    exp_q.push_back(ctl(st, rdy, zr, exp_fault));
    #1;
    check(tag);
    if (ret) exp_instret = exp_instret + 32'd1;
  endtask

  task automatic do_rtype(input string tag);
    opcode_i = 7'b0110011;
    cyc(4'd1, 1'b1, rb(), 1'b0, tag);
    cyc(4'd2, rb(), rb(), 1'b0, tag);
    cyc(4'd7, rb(), rb(), 1'b0, tag);
    cyc(4'd8, rb(), rb(), 1'b1, tag);
  endtask

  task automatic do_load(input int nwait, input string tag);
    opcode_i = 7'b0000011;
    cyc(4'd1, 1'b1, rb(), 1'b0, tag);
    cyc(4'd2, rb(), rb(), 1'b0, tag);
    cyc(4'd3, rb(), rb(), 1'b0, tag);
    for (int i = 0; i < nwait; i++) cyc(4'd4, 1'b0, rb(), 1'b0, tag);
    cyc(4'd4, 1'b1, rb(), 1'b0, tag);
    cyc(4'd6, rb(), rb(), 1'b1, tag);
  endtask

  task automatic do_store(input int nwait, input string tag);
    opcode_i = 7'b0100011;
    cyc(4'd1, 1'b1, rb(), 1'b0, tag);
    cyc(4'd2, rb(), rb(), 1'b0, tag);
    cyc(4'd3, rb(), rb(), 1'b0, tag);
    for (int i = 0; i < nwait; i++) cyc(4'd5, 1'b0, rb(), 1'b0, tag);
    cyc(4'd5, 1'b1, rb(), 1'b1, tag);
  endtask

  task automatic do_beq(input logic z, input string tag);
    opcode_i = 7'b1100011;
    cyc(4'd1, 1'b1, rb(), 1'b0, tag);
    cyc(4'd2, rb(), rb(), 1'b0, tag);
    cyc(4'd9, rb(), z, 1'b1, tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    exp_instret = 32'd0;
    exp_fault   = 2'b00;
    exp_q.push_back(ctl(4'd0, 1'b0, 1'b0, 2'b00));
    check(tag);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    exp_instret = 32'd0;
    exp_fault   = 2'b00;
    rst_i       = 1'b1;
    opcode_i    = 7'd0;
    zero_i      = 1'b0;
    mem_ready_i = 1'b0;

    repeat (2) @(negedge clk_i);
    #1;
    exp_q.push_back(ctl(4'd0, 1'b0, 1'b0, 2'b00));
    check("reset");
    rst_i = 1'b0;
    #1;
    exp_q.push_back(ctl(4'd0, 1'b0, 1'b0, 2'b00));
    check("start");

    do_rtype("rtype");
    do_load(2, "lw_wait2");
    do_beq(1'b1, "beq_taken");
    do_beq(1'b0, "beq_not_taken");
    do_store(0, "sw_zero_wait");
    do_store(3, "sw_ready_at_limit");
    do_load(3, "lw_ready_at_limit");

    // Counter wrap: preload the retire counter during a FETCH stall.
    opcode_i = 7'b0110011;
    cyc(4'd1, 1'b0, rb(), 1'b0, "wrap_stall");
    force dut.instret_d = 32'hFFFF_FFFF;
    @(posedge clk_i);
    #1;
    release dut.instret_d;
    exp_instret = 32'hFFFF_FFFF;
    do_rtype("wrap_rtype");
    do_beq(1'b0, "after_wrap");

    // Illegal opcode traps and stays trapped.
    opcode_i = 7'b1111111;
    cyc(4'd1, 1'b1, rb(), 1'b0, "illegal_fetch");
    cyc(4'd2, rb(), rb(), 1'b0, "illegal_decode");
    exp_fault = 2'b01;
    for (int i = 0; i < 20; i++) cyc(4'd10, rb(), rb(), 1'b0, "illegal_trap");
    async_reset("trap_reset");

    // Reset in the middle of a load wait state.
    do_rtype("pre_abort");
    opcode_i = 7'b0000011;
    cyc(4'd1, 1'b1, rb(), 1'b0, "abort_lw");
    cyc(4'd2, rb(), rb(), 1'b0, "abort_lw");
    cyc(4'd3, rb(), rb(), 1'b0, "abort_lw");
    cyc(4'd4, 1'b0, rb(), 1'b0, "abort_lw");
    async_reset("mem_rd_reset");

    // Store that never completes times out after four wait cycles.
    do_rtype("post_abort");
    opcode_i = 7'b0100011;
    cyc(4'd1, 1'b1, rb(), 1'b0, "sw_timeout");
    cyc(4'd2, rb(), rb(), 1'b0, "sw_timeout");
    cyc(4'd3, rb(), rb(), 1'b0, "sw_timeout");
    for (int i = 0; i < 4; i++) cyc(4'd5, 1'b0, rb(), 1'b0, "sw_timeout_wait");
    exp_fault = 2'b10;
    for (int i = 0; i < 3; i++) cyc(4'd10, rb(), rb(), 1'b0, "sw_timeout_trap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
